// File: rtl/acorn128_step_sequencer.sv
// ACORN-128 step sequencer: walks init, AD, AD pad, message, message pad and finalisation,
// issuing one input-bit/control command per accepted datapath step.
module acorn128_step_sequencer #(
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned INIT_STEPS = 1792,
    parameter int unsigned FIN_STEPS  = 768
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             encrypt_in,
    input  logic [LEN_W-1:0] ad_len_in,
    input  logic [LEN_W-1:0] msg_len_in,
    output logic             step_valid_out,
    input  logic             step_ready_in,
    output logic [2:0]       src_out,
    output logic [6:0]       idx_out,
    output logic             ca_out,
    output logic             cb_out,
    output logic             ks_use_out,
    output logic             encrypt_out,
    output logic [2:0]       phase_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             ready_out
);

    localparam int unsigned PadSteps = 256;
    localparam int unsigned MaxLen   = 128;

    localparam logic [2:0] SrcZero   = 3'd0;
    localparam logic [2:0] SrcKey    = 3'd1;
    localparam logic [2:0] SrcIv     = 3'd2;
    localparam logic [2:0] SrcAd     = 3'd3;
    localparam logic [2:0] SrcMsg    = 3'd4;
    localparam logic [2:0] SrcOne    = 3'd5;
    localparam logic [2:0] SrcKeyInv = 3'd6;

    typedef enum logic [2:0] {
        StIdle, StInit, StAd, StAdPad, StMsg, StMsgPad, StFinal, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  ad_len_q, msg_len_q;
    logic        encrypt_q;
    logic        done_q, done_d;

    logic        start_ok;
    logic        fire;
    logic [10:0] last_idx;
    logic [7:0]  ad_len_sat, msg_len_sat;

    assign ad_len_sat  = (ad_len_in > LEN_W'(MaxLen)) ? 8'(MaxLen) : ad_len_in[7:0];
    assign msg_len_sat = (msg_len_in > LEN_W'(MaxLen)) ? 8'(MaxLen) : msg_len_in[7:0];

    assign start_ok = start_in && (state_q == StIdle || state_q == StDone);
    assign fire     = step_valid_out && step_ready_in;

    always_comb begin
        last_idx = 11'd0;
        case (state_q)
            StInit:   last_idx = 11'(INIT_STEPS - 1);
            StAd:     last_idx = {3'b000, ad_len_q} - 11'd1;
            StAdPad:  last_idx = 11'(PadSteps - 1);
            StMsg:    last_idx = {3'b000, msg_len_q} - 11'd1;
            StMsgPad: last_idx = 11'(PadSteps - 1);
            StFinal:  last_idx = 11'(FIN_STEPS - 1);
            default:  last_idx = 11'd0;
        endcase
    end

    // Zero-length AD/MSG phases are skipped on the same edge as the last step before them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    state_d = StInit;
                    cnt_d   = 11'd0;
                end
            end
            default: begin
                if (fire) begin
                    if (cnt_q == last_idx) begin
                        cnt_d = 11'd0;
                        case (state_q)
                            StInit:   state_d = (ad_len_q != 8'd0) ? StAd : StAdPad;
                            StAd:     state_d = StAdPad;
                            StAdPad:  state_d = (msg_len_q != 8'd0) ? StMsg : StMsgPad;
                            StMsg:    state_d = StMsgPad;
                            StMsgPad: state_d = StFinal;
                            default:  begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 11'd0;
            ad_len_q  <= 8'd0;
            msg_len_q <= 8'd0;
            encrypt_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (start_ok) begin
                ad_len_q  <= ad_len_sat;
                msg_len_q <= msg_len_sat;
                encrypt_q <= encrypt_in;
            end
        end
    end

    // INIT key re-use repeats every 128 steps from 256, so idx is simply cnt mod 128.
    always_comb begin
        src_out    = SrcZero;
        idx_out    = 7'd0;
        ca_out     = 1'b0;
        cb_out     = 1'b0;
        ks_use_out = 1'b0;
        case (state_q)
            StInit: begin
                ca_out  = 1'b1;
                cb_out  = 1'b1;
                idx_out = cnt_q[6:0];
                if (cnt_q < 11'd128)       src_out = SrcKey;
                else if (cnt_q < 11'd256)  src_out = SrcIv;
                else if (cnt_q == 11'd256) src_out = SrcKeyInv;
                else                       src_out = SrcKey;
            end
            StAd: begin
                src_out = SrcAd;
                idx_out = cnt_q[6:0];
                ca_out  = 1'b1;
                cb_out  = 1'b1;
            end
            StAdPad, StMsgPad: begin
                src_out = (cnt_q == 11'd0) ? SrcOne : SrcZero;
                ca_out  = (cnt_q < 11'd128);
                cb_out  = (state_q == StAdPad);
            end
            StMsg: begin
                src_out    = SrcMsg;
                idx_out    = cnt_q[6:0];
                ca_out     = 1'b1;
                ks_use_out = 1'b1;
            end
            StFinal: begin
                ca_out = 1'b1;
                cb_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_out       = (state_q != StIdle) && (state_q != StDone);
    assign step_valid_out = busy_out;
    assign ready_out      = (state_q == StDone);
    assign done_out       = done_q;
    assign encrypt_out    = encrypt_q;
    assign phase_out      = state_q;

endmodule

// File: tb/tb_acorn128_step_sequencer.sv
// Directed bench for acorn128_step_sequencer: full sequences checked step by step against a
// phase/step reference built from the step-count layout of ACORN-128.
module tb_acorn128_step_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic       encrypt_in;
    logic [7:0] ad_len_in;
    logic [7:0] msg_len_in;
    logic       step_valid_out;
    logic       step_ready_in;
    logic [2:0] src_out;
    logic [6:0] idx_out;
    logic       ca_out;
    logic       cb_out;
    logic       ks_use_out;
    logic       encrypt_out;
    logic [2:0] phase_out;
    logic       busy_out;
    logic       done_out;
    logic       ready_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acorn128_step_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .encrypt_in     (encrypt_in),
        .ad_len_in      (ad_len_in),
        .msg_len_in     (msg_len_in),
        .step_valid_out (step_valid_out),
        .step_ready_in  (step_ready_in),
        .src_out        (src_out),
        .idx_out        (idx_out),
        .ca_out         (ca_out),
        .cb_out         (cb_out),
        .ks_use_out     (ks_use_out),
        .encrypt_out    (encrypt_out),
        .phase_out      (phase_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .ready_out      (ready_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {phase, src, idx, ca, cb, ks_use} expected for global step k of one run.
    function automatic logic [15:0] exp_step(input int k, input int ad, input int msg);
        logic [2:0] ph;
        logic [2:0] src;
        logic [6:0] idx;
        logic       ca;
        logic       cb;
        logic       ks;
        int         r;
        r = k; ph = 3'd1; src = 3'd0; idx = 7'd0; ca = 1'b1; cb = 1'b1; ks = 1'b0;
        if (r < 1792) begin
            if (r < 128)       begin src = 3'd1; idx = 7'(r); end
            else if (r < 256)  begin src = 3'd2; idx = 7'(r - 128); end
            else if (r == 256) begin src = 3'd6; idx = 7'd0; end
            else               begin src = 3'd1; idx = 7'((r - 256) % 128); end
        end else begin
            r -= 1792;
            if (r < ad) begin
                ph = 3'd2; src = 3'd3; idx = 7'(r);
            end else begin
                r -= ad;
                if (r < 256) begin
                    ph = 3'd3; src = (r == 0) ? 3'd5 : 3'd0; ca = (r < 128);
                end else begin
                    r -= 256;
                    if (r < msg) begin
                        ph = 3'd4; src = 3'd4; idx = 7'(r); cb = 1'b0; ks = 1'b1;
                    end else begin
                        r -= msg;
                        if (r < 256) begin
                            ph = 3'd5; src = (r == 0) ? 3'd5 : 3'd0; ca = (r < 128); cb = 1'b0;
                        end else begin
                            ph = 3'd6; src = 3'd0;
                        end
                    end
                end
            end
        end
        return {ph, src, idx, ca, cb, ks};
    endfunction

    // Runs one sequence; poke_c > 0 pulses start_in (with changed mode/lengths) at that cycle.
    task automatic run_seq(input int ad, input int msg, input bit enc, input bit stall,
                           input int poke_c, input string name);
        int  ad_eff;
        int  msg_eff;
        int  steps;
        int  done_c;
        bit  rdy;
        ad_eff  = (ad > 128) ? 128 : ad;
        msg_eff = (msg > 128) ? 128 : msg;
        steps   = 0;
        done_c  = 0;
        @(negedge clk);
        start_in = 1'b1; encrypt_in = enc; ad_len_in = 8'(ad); msg_len_in = 8'(msg);
        step_ready_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0; encrypt_in = ~enc; ad_len_in = 8'd3; msg_len_in = 8'd3;
        for (int c = 1; c <= 20000 && done_c == 0; c++) begin
            if (step_valid_out)
                check_eq({name, "_step"},
                         32'({phase_out, src_out, idx_out, ca_out, cb_out, ks_use_out}),
                         32'(exp_step(steps, ad_eff, msg_eff)));
            if (done_out) done_c = c;
            start_in = (c == poke_c);
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            step_ready_in = rdy;
            if (step_valid_out && rdy) steps++;
            if (done_c == 0) @(negedge clk);
        end
        start_in = 1'b0;
        check_eq({name, "_done_seen"}, 32'(done_c != 0), 32'd1);
        check_eq({name, "_steps"}, steps, 1792 + ad_eff + 256 + msg_eff + 256 + 768);
        if (!stall) check_eq({name, "_done_cycle"}, done_c, 1793 + ad_eff + 256 + msg_eff + 256 + 768);
        check_eq({name, "_enc"}, 32'(encrypt_out), 32'(enc));
        check_eq({name, "_ready_at_done"}, 32'(ready_out), 32'd1);
        @(negedge clk);
        check_eq({name, "_done_pulse"}, 32'({done_out, ready_out, busy_out, step_valid_out}),
                 32'b0100);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; encrypt_in = 1'b0; ad_len_in = 8'd0; msg_len_in = 8'd0;
        step_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs",
                 32'({step_valid_out, src_out, idx_out, ca_out, cb_out, ks_use_out, encrypt_out,
                      phase_out, busy_out, done_out, ready_out}), 32'd0);
        rst = 1'b0;

        run_seq(0, 0, 1'b1, 1'b0, 0, "empty");
        // Restart straight from DONE, full lengths, random stalls.
        run_seq(128, 128, 1'b0, 1'b1, 0, "full_stall");
        // Oversized AD saturates; start pulse mid-MSG must be ignored.
        run_seq(200, 5, 1'b1, 1'b0, 1792 + 128 + 256 + 3 + 1, "sat_poke");

        // Abort at step 1000.
        @(negedge clk);
        start_in = 1'b1; ad_len_in = 8'd16; msg_len_in = 8'd16; encrypt_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (1000) @(negedge clk);
        check_eq("abort_pre_step", 32'({phase_out, src_out, idx_out}),
                 32'({3'd1, 3'd1, 7'd104}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_outputs",
                 32'({step_valid_out, src_out, idx_out, ca_out, cb_out, ks_use_out, encrypt_out,
                      phase_out, busy_out, done_out, ready_out}), 32'd0);
        run_seq(0, 0, 1'b0, 1'b0, 0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
